// File: rtl/riptide_pkg.sv
// Shared definitions for the stream demux: way count, select width and
// the select-to-one-hot decode used to steer push enables.
package riptide_pkg;

  localparam int DEMUX_WAYS = 8;
  localparam int SEL_W      = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // One-hot channel enable for a given select value.
  function automatic logic [DEMUX_WAYS-1:0] sel_decode(input sel_t sel);
    return DEMUX_WAYS'(1) << sel;
  endfunction

endpackage

// File: rtl/demux1to8_stream_fifo.sv
// Small per-channel FIFO. The count register separates full from empty, so
// the pointers are plain modulo-DEPTH counters. A push into an empty FIFO
// becomes visible at head/valid on the following cycle; there is no bypass.
module stream_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  output logic                     full,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  // Pointer and count updates; simultaneous push and pop leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // State register; reset clears storage too so no stale data can surface.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign full  = (count_q == CW'(DEPTH));
  assign valid = (count_q != '0);
  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/demux1to8_stream.sv
// 1-to-8 stream steer. Each token carries its destination select; every
// output channel owns a FIFO so a stalled consumer only blocks tokens aimed
// at it.
//
// Handshake: a transfer happens on a rising clock edge when valid && ready
// are both high. in_ready depends only on registered FIFO state and in_sel
// (never on out_ready), and is held low while reset is asserted. Outputs
// hold valid and data stable until popped; out_data is zero when not valid.
module demux1to8_stream
  import riptide_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    in_valid,
  output logic                                    in_ready,
  input  logic [WIDTH-1:0]                        in_data,
  input  sel_t                                    in_sel,
  output logic [DEMUX_WAYS-1:0]                   out_valid,
  input  logic [DEMUX_WAYS-1:0]                   out_ready,
  output logic [DEMUX_WAYS-1:0][WIDTH-1:0]        out_data,
  output logic [DEMUX_WAYS-1:0][$clog2(DEPTH):0]  occupancy
);

  logic [DEMUX_WAYS-1:0] fifo_full;
  logic [DEMUX_WAYS-1:0] fifo_valid;
  logic [DEMUX_WAYS-1:0] push_en;
  logic [DEMUX_WAYS-1:0] pop_en;

  // Accept when the addressed channel has room; refuse everything during reset.
  always_comb begin
    in_ready = !reset && !fifo_full[in_sel];
    push_en  = '0;
    if (in_valid && in_ready) push_en = sel_decode(in_sel);
  end

  for (genvar g = 0; g < DEMUX_WAYS; g++) begin : g_ch
    logic [WIDTH-1:0] head;

    stream_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_en[g]),
      .push_data (in_data),
      .full      (fifo_full[g]),
      .pop       (pop_en[g]),
      .head      (head),
      .valid     (fifo_valid[g]),
      .count     (occupancy[g])
    );

    assign pop_en[g]    = fifo_valid[g] && out_ready[g];
    assign out_valid[g] = fifo_valid[g];
    assign out_data[g]  = fifo_valid[g] ? head : '0;
  end

endmodule

// File: tb/tb_demux1to8_stream.sv
// Bench for demux1to8_stream: directed scenarios followed by randomized
// traffic, all compared against per-channel reference queues.
module tb_demux1to8_stream;

  localparam int W  = 32;
  localparam int D  = 2;
  localparam int CW = $clog2(D) + 1;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic                 in_ready;
  logic [W-1:0]         in_data;
  logic [2:0]           in_sel;
  logic [7:0]           out_valid;
  logic [7:0]           out_ready;
  logic [7:0][W-1:0]    out_data;
  logic [7:0][CW-1:0]   occupancy;

  demux1to8_stream #(.WIDTH(W), .DEPTH(D)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  // Clock
  always #5 clk = ~clk;

  // Scoreboard: expected contents of each channel in FIFO order.
  logic [W-1:0] exp_q [8][$];
  int checks   = 0;
  int failures = 0;
  logic last_acc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    for (int i = 0; i < 8; i++) begin
      int n;
      n = exp_q[i].size();
      chk($sformatf("out_valid[%0d]", i), 64'(out_valid[i]), 64'(n != 0));
      chk($sformatf("out_data[%0d]", i), 64'(out_data[i]), (n != 0) ? 64'(exp_q[i][0]) : 64'd0);
      chk($sformatf("occupancy[%0d]", i), 64'(occupancy[i]), 64'(n));
    end
  endtask

  // One clock cycle: check in_ready, predict transfers from the queues,
  // advance the clock, update the queues, then check every output.
  task automatic tick();
    logic       acc;
    logic [7:0] pops;
    #1;
    chk("in_ready", 64'(in_ready), 64'(exp_q[in_sel].size() < D));
    acc = in_valid && (exp_q[in_sel].size() < D);
    for (int i = 0; i < 8; i++) pops[i] = out_ready[i] && (exp_q[i].size() > 0);
    @(posedge clk);
    for (int i = 0; i < 8; i++) if (pops[i]) void'(exp_q[i].pop_front());
    if (acc) exp_q[in_sel].push_back(in_data);
    last_acc = acc;
    #1;
    check_outputs();
  endtask

  task automatic clear_model();
    for (int i = 0; i < 8; i++) exp_q[i].delete();
  endtask

  // Stability rules: stalled outputs hold, stalled producer holds.
  logic [7:0]        p_ov, p_or;
  logic [7:0][W-1:0] p_od;
  logic              p_iv, p_ir, p_ok = 1'b0;
  logic [2:0]        p_sel;
  logic [W-1:0]      p_data;
  always @(posedge clk) begin
    if (!reset && p_ok) begin
      for (int i = 0; i < 8; i++) begin
        if (p_ov[i] && !p_or[i]) begin
          chk($sformatf("hold_valid[%0d]", i), 64'(out_valid[i]), 64'd1);
          chk($sformatf("hold_data[%0d]", i), 64'(out_data[i]), 64'(p_od[i]));
        end
      end
      if (p_iv && !p_ir) begin
        chk("producer_valid", 64'(in_valid), 64'd1);
        chk("producer_sel", 64'(in_sel), 64'(p_sel));
        chk("producer_data", 64'(in_data), 64'(p_data));
      end
    end
    p_ov   <= out_valid;
    p_or   <= out_ready;
    p_od   <= out_data;
    p_iv   <= in_valid;
    p_ir   <= in_ready;
    p_sel  <= in_sel;
    p_data <= in_data;
    p_ok   <= !reset;
  end

  initial begin
    logic stalled;
    int   guard;

    // Reset state
    reset = 1'b1; in_valid = 1'b0; in_sel = '0; in_data = '0; out_ready = '0;
    last_acc = 1'b0;
    clear_model();
    #2;
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_out_data", 64'(out_data[0]) | 64'(out_data[7]), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1 chk("release_in_ready", 64'(in_ready), 64'd1);

    // 1: one token per channel, all consumers ready
    out_ready = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; in_sel = 3'(i); in_data = 32'hA0 + 32'(i);
      tick();
      chk($sformatf("t1_data[%0d]", i), 64'(out_data[i]), 64'(32'hA0 + 32'(i)));
    end
    in_valid = 1'b0;
    tick();
    chk("t1_drained", 64'(out_valid), 64'd0);

    // 2/3: fill channel 3 while blocked, steer past it to channel 5
    out_ready = 8'hF7;
    in_valid = 1'b1; in_sel = 3'd3; in_data = 32'h11; tick();
    in_data = 32'h22; tick();
    in_sel = 3'd5; in_data = 32'h5A; tick();
    chk("t3_ch5_accepted", 64'(last_acc), 64'd1);
    in_sel = 3'd3; in_data = 32'h33;
    #1;
    chk("t2_full_in_ready", 64'(in_ready), 64'd0);
    chk("t2_occ3", 64'(occupancy[3]), 64'd2);
    tick(); tick();
    chk("t2_head_held", 64'(out_data[3]), 64'h11);
    out_ready = 8'hFF;
    tick();
    chk("t2_second", 64'(out_data[3]), 64'h22);
    tick();
    chk("t2_third_accepted", 64'(last_acc), 64'd1);
    chk("t2_third", 64'(out_data[3]), 64'h33);
    in_valid = 1'b0;
    tick();

    // 4: push and pop on the same channel in one cycle
    out_ready = 8'hFB;
    in_valid = 1'b1; in_sel = 3'd2; in_data = 32'h44; tick();
    out_ready = 8'hFF; in_data = 32'h55; tick();
    chk("t4_occ2", 64'(occupancy[2]), 64'd1);
    chk("t4_data2", 64'(out_data[2]), 64'h55);
    in_valid = 1'b0;
    tick();

    // 5: asynchronous reset with data held in channels 0 and 7
    out_ready = 8'h00;
    in_valid = 1'b1; in_sel = 3'd0; in_data = 32'h70; tick();
    in_sel = 3'd7; in_data = 32'h77; tick();
    in_valid = 1'b0;
    chk("t5_pre_valid", 64'(out_valid), 64'h81);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_valid", 64'(out_valid), 64'd0);
    chk("t5_async_occ", 64'(occupancy), 64'd0);
    chk("t5_async_ready", 64'(in_ready), 64'd0);
    clear_model();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    out_ready = 8'hFF;
    repeat (3) tick();
    chk("t5_no_stale", 64'(out_valid), 64'd0);

    // 6: randomized traffic
    in_valid = 1'b0;
    last_acc = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      stalled = in_valid && !last_acc;
      if (!stalled) begin
        in_valid = 1'($urandom_range(0, 1));
        in_sel   = 3'($urandom_range(0, 7));
        in_data  = $urandom;
      end
      out_ready = 8'($urandom_range(0, 255));
      tick();
    end
    // Finish any stalled token, then drain everything.
    out_ready = 8'hFF;
    guard = 0;
    while (in_valid && !last_acc && guard < 10) begin
      tick();
      guard++;
    end
    chk("drain_accept_bound", 64'(in_valid && !last_acc), 64'd0);
    in_valid = 1'b0;
    repeat (4) tick();
    chk("final_empty", 64'(out_valid), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
